// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: 2-cycle multiply path, radix-2 restoring divider.
// Optional MULDIV_SPECIAL_BYPASS_EN retires divide-by-zero and signed overflow straight from IDLE.

package riscv_defines;
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_SLTU   = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alucontrol_t;
endpackage

module muldiv_sequencer
    import riscv_defines::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  alucontrol_t     alucontrol,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    alucontrol_t        op_q, op_d;
    logic [XLEN-1:0]    opa_q, opa_d;     // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0]    opb_q, opb_d;     // multiplier, or divisor magnitude
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic               b_zero_q, b_zero_d;
    logic [XLEN-1:0]    result_q, result_d;

    logic               is_div_in, signed_a_in, signed_b_in;
    logic               a_neg_in, b_neg_in;

    always_comb begin
        is_div_in   = 1'b0;
        signed_a_in = 1'b0;
        signed_b_in = 1'b0;
        case (alucontrol)
            ALU_MULH:           begin signed_a_in = 1'b1; signed_b_in = 1'b1; end
            ALU_MULHSU:         signed_a_in = 1'b1;
            ALU_DIV, ALU_REM:   begin is_div_in = 1'b1; signed_a_in = 1'b1; signed_b_in = 1'b1; end
            ALU_DIVU, ALU_REMU: is_div_in = 1'b1;
            default:            ;
        endcase
    end

    assign a_neg_in = signed_a_in & src_a[XLEN-1];
    assign b_neg_in = signed_b_in & src_b[XLEN-1];

`ifdef MULDIV_SPECIAL_BYPASS_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    logic            div_zero_in, div_ovf_in, special_in, rem_in;
    logic [XLEN-1:0] special_res;
    assign div_zero_in = is_div_in && (src_b == '0);
    assign div_ovf_in  = is_div_in && signed_b_in && (src_a == INT_MIN) && (src_b == '1);
    assign special_in  = div_zero_in || div_ovf_in;
    assign rem_in      = (alucontrol == ALU_REM) || (alucontrol == ALU_REMU);
    always_comb begin
        if (div_zero_in) special_res = rem_in ? src_a : '1;
        else             special_res = rem_in ? '0 : INT_MIN;
    end
`endif

    // Sign-extended operands make one unsigned 2*XLEN multiply cover all four variants.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    assign prod = {{XLEN{a_neg_q}}, opa_q} * {{XLEN{b_neg_q}}, opb_q};

    always_comb begin
        mul_res = '0;
        case (op_q)
            ALU_MUL:                        mul_res = prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: mul_res = prod[2*XLEN-1:XLEN];
            default:                        mul_res = '0;
        endcase
    end

    logic [XLEN:0]   rem_sh, trial;
    logic            q_bit;
    logic [XLEN-1:0] rem_next, quo_next, quo_fix, rem_fix, div_res;

    assign rem_sh   = {rem_q, opa_q[XLEN-1]};
    assign trial    = rem_sh - {1'b0, opb_q};
    assign q_bit    = ~trial[XLEN];
    assign rem_next = q_bit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_next = {opa_q[XLEN-2:0], q_bit};

    // A zero divisor keeps the all-ones quotient whatever the dividend sign.
    assign quo_fix  = ((a_neg_q ^ b_neg_q) && !b_zero_q) ? -quo_next : quo_next;
    assign rem_fix  = a_neg_q ? -rem_next : rem_next;
    assign div_res  = ((op_q == ALU_REM) || (op_q == ALU_REMU)) ? rem_fix : quo_fix;

    // NOTE: every _d is given its hold value first so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    op_d     = alucontrol;
                    a_neg_d  = a_neg_in;
                    b_neg_d  = b_neg_in;
                    b_zero_d = (src_b == '0);
                    rem_d    = '0;
                    cnt_d    = '0;
                    if (is_div_in) begin
                        opa_d   = a_neg_in ? -src_a : src_a;
                        opb_d   = b_neg_in ? -src_b : src_b;
                        state_d = S_DIV;
`ifdef MULDIV_SPECIAL_BYPASS_EN
                        if (special_in) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end
`endif
                    end else begin
                        opa_d   = src_a;
                        opb_d   = src_b;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                result_d = mul_res;
                state_d  = S_DONE;
            end
            S_DIV: begin
                opa_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    result_d = div_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) state_d = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= ALU_ADD;
            opa_q    <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: transaction-level reference model plus directed cases.
// Honours MULDIV_SPECIAL_BYPASS_EN for the special-case latency.

module tb_muldiv_sequencer;
    import riscv_defines::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    alucontrol_t alucontrol = ALU_ADD;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alucontrol(alucontrol), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(alucontrol_t op, logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, ub;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = int'(a);
        ib = int'(b);
        case (op)
            ALU_MUL:    return a * b;
            ALU_MULH:   begin p = 64'(sa * sb);                return p[63:32]; end
            ALU_MULHSU: begin p = 64'(sa * ub);                return p[63:32]; end
            ALU_MULHU:  begin p = {32'b0, a} * {32'b0, b};     return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            ALU_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(alucontrol_t op, logic [31:0] a, logic [31:0] b);
        bit is_div, special;
        is_div  = (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
        special = is_div && ((b == 0) ||
                  (((op == ALU_DIV) || (op == ALU_REM)) && a == 32'h80000000 && b == 32'hFFFFFFFF));
        if (!is_div) return 2;
`ifdef MULDIV_SPECIAL_BYPASS_EN
        if (special) return 1;
`else
        if (special) return 33;
`endif
        return 33;
    endfunction

    // Model state: one pending op, edges elapsed since its accept edge.
    bit          m_pend = 1'b0;
    int          m_age  = 0;
    int          m_lat  = 2;
    logic [31:0] m_res  = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_pend <= 1'b0;
        end else if (flush) begin
            m_pend <= 1'b0;
        end else if (!m_pend) begin
            if (in_valid) begin
                m_pend <= 1'b1;
                m_age  <= 0;
                m_lat  <= ref_latency(alucontrol, src_a, src_b);
                m_res  <= ref_result(alucontrol, src_a, src_b);
            end
        end else if (m_age >= m_lat - 1 && out_ready) begin
            m_pend <= 1'b0;
        end else if (m_age < 1000) begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(!m_pend));
            check("busy", 32'(busy), 32'(m_pend));
            check("busy_eq_not_in_ready", 32'(busy), 32'(!in_ready));
            check("out_valid", 32'(out_valid), 32'(m_pend && m_age >= m_lat - 1));
            if (m_pend && m_age >= m_lat - 1)
                check("result", result, m_res);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_valid(output int lat);
        int k;
        k = 0;
        while (!out_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        lat = out_valid ? k + 1 : -1;
    endtask

    task automatic run_op(input string name, input alucontrol_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; alucontrol = op; src_a = a; src_b = b; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check(name, result, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_retired"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic alucontrol_t rnd_op();
        alucontrol_t m_ops [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                   ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        int idx;
        idx = $urandom_range(0, 8);
        if (idx == 8) return alucontrol_t'(5'($urandom_range(0, 6)));
        return m_ops[idx];
    endfunction

`ifdef MULDIV_SPECIAL_BYPASS_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    initial begin
        int lat, cyc, seen;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'h0);
        reset = 1'b0;
        chk_en = 1'b1;

        // multiplies
        run_op("mulh_m2x3", ALU_MULH, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 2);
        run_op("mul_m2x3", ALU_MUL, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 2);
        run_op("mulhsu_m1xmax", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
        run_op("mulhu_maxxmax", ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
        run_op("unsupported_add", ALU_ADD, 32'h5, 32'h6, 32'h0, 2);

        // divides
        run_op("div_m7_2", ALU_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
        run_op("rem_m7_2", ALU_REM, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33);
        run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, 33);

        // divide by zero and overflow
        run_op("div_5_0", ALU_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT);
        run_op("remu_5_0", ALU_REMU, 32'd5, 32'd0, 32'd5, SPECIAL_LAT);
        run_op("div_m5_0", ALU_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT);
        run_op("rem_m5_0", ALU_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, SPECIAL_LAT);
        run_op("div_ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT);
        run_op("rem_ovf", ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, SPECIAL_LAT);
        run_op("divu_min_max", ALU_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33);

        // backpressure
        @(negedge clk);
        in_valid = 1'b1; alucontrol = ALU_DIVU; src_a = 32'd100; src_b = 32'd7; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; alucontrol = ALU_MUL; src_a = 32'd3; src_b = 32'd4;
            @(negedge clk);
            check("bp_result_held", result, 32'd14);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_after_take", 32'(in_ready), 32'd1);
        check("bp_no_extra_result", 32'(out_valid), 32'd0);

        // flush mid divide
        in_valid = 1'b1; alucontrol = ALU_DIV; src_a = 32'd1000; src_b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_div_idle", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_div_no_valid", 32'(seen), 32'd0);

        // flush beats in_valid in IDLE
        in_valid = 1'b1; flush = 1'b1; alucontrol = ALU_MUL; src_a = 32'd2; src_b = 32'd2;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_in_valid", 32'(busy), 32'd0);

        // flush in DONE with out_ready discards the result
        in_valid = 1'b1; alucontrol = ALU_MUL; src_a = 32'd6; src_b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check("flush_done_latency", 32'(lat), 32'd2);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done_out_valid", 32'(out_valid), 32'd0);

        // reset mid divide, with in_valid also high
        in_valid = 1'b1; alucontrol = ALU_DIVU; src_a = 32'hDEADBEEF; src_b = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_result", result, 32'h0);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            in_valid = 1'b1; alucontrol = rnd_op(); src_a = rnd_operand(); src_b = rnd_operand();
            out_ready = ($urandom_range(0, 3) != 0); flush = 1'b0;
            @(negedge clk);
            cyc = 0;
            do begin
                in_valid   = ($urandom_range(0, 3) == 0);
                alucontrol = rnd_op();
                src_a      = $urandom;
                src_b      = $urandom;
                out_ready  = ($urandom_range(0, 3) != 0);
                flush      = ($urandom_range(0, 255) == 0);
                @(negedge clk);
                cyc++;
            end while (!in_ready && cyc < 200);
            flush = 1'b0;
            in_valid = 1'b0;
            check("random_retire_bound", 32'(cyc < 200), 32'd1);
        end
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M operations selected by `alucontrol` (ALU_MUL … ALU_REMU). It accepts one operation at a time over a valid/ready handshake. Multiplies complete in a fixed 2-cycle path. Divides and remainders run on an iterative radix-2 restoring datapath. It sits beside the single-cycle ALU in the execute stage, and its `busy` output stalls the pipeline while an M-extension operation is in flight.

## Interface
- `XLEN`, 32: operand/result width; 32 is the only supported value.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: synchronous kill of any in-flight op.
- `in_valid` input 1: request present.
- `in_ready` output 1: high only in IDLE.
- `alucontrol` input alucontrol_t: op select (riscv_defines).
- `src_a` input XLEN: rs1 / dividend / multiplicand.
- `src_b` input XLEN: rs2 / divisor / multiplier.
- `out_valid` output 1: result valid, held until taken.
- `out_ready` input 1: consumer accepts result.
- `result` output XLEN: selected result word.
- `busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, MUL, DIV, DONE.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid`=1 and `flush`=0: latch op, operands and operand signs.
  - Go to MUL for ALU_MUL/MULH/MULHSU/MULHU, otherwise DIV.
- **Unsupported op:** any `alucontrol` value outside the eight M ops takes the MUL path and returns `result`=0.
- **MUL state (1 cycle)**
  - Form a 2·XLEN product from sign/zero-extended operands:
    - MULH: signed×signed.
    - MULHSU: signed×unsigned.
    - MUL/MULHU: unsigned×unsigned.
  - Register the product, then go to DONE.
  - MUL returns bits [31:0]. The other three ops return bits [63:32].
- **DIV state (XLEN cycles)**
  - Signed ops (DIV/REM) divide the absolute values. Unsigned ops use the raw operands.
  - Iteration counter runs from 0 to XLEN-1. Each cycle performs shift, trial subtract and restore.
  - After the iteration with counter = XLEN-1, go to DONE.
- **DONE**
  - `out_valid`=1.
  - Signed results are corrected when leaving DIV:
    - Quotient is negated when the dividend and divisor signs differ.
    - Remainder takes the sign of the dividend.
  - On `out_valid`&&`out_ready`, go to IDLE.
  - `result` stays stable while `out_valid`=1 and `out_ready`=0.
- **Architectural results for special cases** (fall out of the algorithm; must match):
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- **Flush**
  - Asserted in any state, the next state is IDLE and `out_valid` drops the next cycle.
  - Flush beats `in_valid` in the same cycle: nothing is accepted.
  - A flush in DONE discards the result even if `out_ready`=1 that cycle.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `busy`=0, `out_valid`=0, `result`=0, counter=0.
- Reset has priority over `flush` and `in_valid`.
- **Multiply latency:** accept at edge N → `out_valid` high in cycle N+2.
- **Divide latency:** accept at edge N → `out_valid` high in cycle N+XLEN+1 (N+33).
- The handshake is single-occupancy: `in_ready`=0 from the accept edge until the cycle after the result is taken.
- There is no back-to-back issue in the retire cycle. Minimum issue interval is 3 cycles for multiplies and XLEN+2 cycles for divides.
- `busy` = !IDLE, registered, with no combinational path from `in_valid`.

## Configuration
- Macro: `MULDIV_SPECIAL_BYPASS_EN`.
- **Defined:** in IDLE, a divide/remainder with `src_b`=0, or a signed op with `src_a`=0x80000000 and `src_b`=0xFFFFFFFF, goes directly to DONE with the architectural result.
  - Latency drops to `out_valid` in cycle N+1.
- **Undefined:** those cases run all XLEN iterations with identical results and the standard N+33 latency.

## Test plan
- **MULH:** reset, then MULH `src_a`=0xFFFFFFFE (-2), `src_b`=0x00000003 → `out_valid` in cycle N+2, `result`=0xFFFFFFFF. Repeat as MUL → 0xFFFFFFFA.
- **DIV/REM:** DIV `src_a`=-7 (0xFFFFFFF9), `src_b`=2 → `result`=0xFFFFFFFD at N+33. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- **Divide by zero and overflow:**
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - Latency: N+1 with `MULDIV_SPECIAL_BYPASS_EN`, N+33 without.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after DIVU 100/7 completes → `result` stays 14, `in_ready`=0, a new `in_valid` is ignored. Raise `out_ready` → IDLE next cycle.
- **Flush:**
  - Assert `flush` at iteration 10 of a DIV → `out_valid` never rises, IDLE next cycle.
  - Assert `flush` and `in_valid` together in IDLE → nothing accepted.
  - Assert `reset` mid-DIV → all outputs at reset values the next cycle.
- **Random:** 2000 random ops, operand mix biased to 0, 1, -1, 0x80000000, 0x7FFFFFFF → every result matches the reference model. `busy` equals !`in_ready` every cycle.
